// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle for the four-master round-robin Wishbone arbiter.
// The slave modport is the arbiter's view; master is the environment's.
interface wb_rr_arbiter_if;
  logic [3:0]   m_cyc_i;
  logic [3:0]   m_stb_i;
  logic [3:0]   m_we_i;
  logic [127:0] m_adr_i;
  logic [127:0] m_dat_i;
  logic [15:0]  m_sel_i;
  logic [11:0]  m_cti_i;
  logic [31:0]  m_dat_o;
  logic [3:0]   m_ack_o;
  logic [3:0]   m_err_o;
  logic         s_cyc_o;
  logic         s_stb_o;
  logic         s_we_o;
  logic [31:0]  s_adr_o;
  logic [31:0]  s_dat_o;
  logic [3:0]   s_sel_o;
  logic [2:0]   s_cti_o;
  logic [31:0]  s_dat_i;
  logic         s_ack_i;
  logic [1:0]   grant_o;
  logic         timeout_o;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i,
    input  m_dat_i, m_sel_i, m_cti_i,
    input  s_dat_i, s_ack_i,
    output m_dat_o, m_ack_o, m_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o,
    output s_dat_o, s_sel_o, s_cti_o,
    output grant_o, timeout_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i,
    output m_dat_i, m_sel_i, m_cti_i,
    output s_dat_i, s_ack_i,
    input  m_dat_o, m_ack_o, m_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o,
    input  s_dat_o, s_sel_o, s_cti_o,
    input  grant_o, timeout_o
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Four-master round-robin Wishbone arbiter onto one shared slave,
// with a stall watchdog that aborts strobes the slave never acks.
module wb_rr_arbiter #(
  parameter int unsigned TIMEOUT = 1023
) (
  input logic           sys_clk,
  input logic           sys_rst,
  wb_rr_arbiter_if.slave bus
);

  localparam logic [15:0] TO = 16'(TIMEOUT);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  last_q, last_d;
  logic [15:0] cnt_q, cnt_d;

  logic [1:0]  win, idx;
  logic        found;

  logic        own_cyc, own_stb, own_we;
  logic [31:0] own_adr, own_dat;
  logic [3:0]  own_sel;
  logic [2:0]  own_cti;

  logic        stb, abort;
  logic        cyc_o, stb_o, we_o;
  logic [31:0] adr_o, dat_o;
  logic [3:0]  sel_o, ack_o, err_o;
  logic [2:0]  cti_o;

  // First requester after the previous owner wins.
  always_comb begin
    win   = last_q;
    idx   = last_q;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && bus.m_cyc_i[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    own_cti = '0;
    for (int n = 0; n < 4; n++) begin
      if (grant_q == 2'(n)) begin
        own_cyc = bus.m_cyc_i[n];
        own_stb = bus.m_stb_i[n];
        own_we  = bus.m_we_i[n];
        own_adr = bus.m_adr_i[32*n +: 32];
        own_dat = bus.m_dat_i[32*n +: 32];
        own_sel = bus.m_sel_i[4*n +: 4];
        own_cti = bus.m_cti_i[3*n +: 3];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    stb     = 1'b0;
    abort   = 1'b0;
    cyc_o   = 1'b0;
    stb_o   = 1'b0;
    we_o    = 1'b0;
    adr_o   = '0;
    dat_o   = '0;
    sel_o   = '0;
    cti_o   = '0;
    ack_o   = '0;
    err_o   = '0;
    unique case (state_q)
      IDLE: begin
        if (|bus.m_cyc_i) begin
          state_d = GRANT;
          grant_d = win;
          last_d  = win;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        stb   = own_cyc & own_stb;
        // A late ack in the abort cycle still completes the transfer.
        abort = stb & ~bus.s_ack_i & (cnt_q == TO);
        cyc_o = own_cyc & ~abort;
        stb_o = stb & ~abort;
        we_o  = own_we;
        adr_o = own_adr;
        dat_o = own_dat;
        sel_o = own_sel;
        cti_o = own_cti;
        ack_o[grant_q] = bus.s_ack_i;
        err_o[grant_q] = abort;
        if (bus.s_ack_i) begin
          cnt_d = '0;
        end else if (stb) begin
          cnt_d = cnt_q + 16'd1;
        end
        if (!own_cyc || abort) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      grant_q <= 2'd0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.s_cyc_o   = cyc_o;
  assign bus.s_stb_o   = stb_o;
  assign bus.s_we_o    = we_o;
  assign bus.s_adr_o   = adr_o;
  assign bus.s_dat_o   = dat_o;
  assign bus.s_sel_o   = sel_o;
  assign bus.s_cti_o   = cti_o;
  assign bus.m_ack_o   = ack_o;
  assign bus.m_err_o   = err_o;
  assign bus.m_dat_o   = bus.s_dat_i;
  assign bus.grant_o   = grant_q;
  assign bus.timeout_o = abort;

endmodule

// File: doc/wb_rr_arbiter.md
WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023, meaning stalled-strobe cycles tolerated before abort (legal range 1..65535).
REQ-002 SHALL have port sys_clk  in  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port sys_rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port m_cyc_i  in  4  master cycle requests; bit n belongs to master n.
REQ-005 SHALL have port m_stb_i  in  4  master strobes.
REQ-006 SHALL have port m_we_i  in  4  master write enables.
REQ-007 SHALL have port m_adr_i  in  128  master addresses; master n occupies bits [32n+31:32n].
REQ-008 SHALL have port m_dat_i  in  128  master write data, packed as m_adr_i.
REQ-009 SHALL have port m_sel_i  in  16  master byte selects; master n occupies bits [4n+3:4n].
REQ-010 SHALL have port m_cti_i  in  12  master cycle type identifiers; master n occupies bits [3n+2:3n].
REQ-011 SHALL have port m_dat_o  out  32  read data broadcast to all masters.
REQ-012 SHALL have port m_ack_o  out  4  per-master acknowledge.
REQ-013 SHALL have port m_err_o  out  4  per-master timeout error.
REQ-014 SHALL have ports s_cyc_o, s_stb_o, s_we_o  out  1 each  shared-slave Wishbone controls.
REQ-015 SHALL have ports s_adr_o 32, s_dat_o 32, s_sel_o 4, s_cti_o 3  out  shared-slave address, write data, select, cycle type.
REQ-016 SHALL have ports s_dat_i 32, s_ack_i 1  in  slave read data and acknowledge.
REQ-017 SHALL have port grant_o  out  2  index of the current or last owner.
REQ-018 SHALL have port timeout_o  out  1  one-cycle pulse on every abort.

Function
REQ-019 SHALL implement an FSM with two states, IDLE and GRANT.
REQ-020 IDLE: s_cyc_o, s_stb_o, s_we_o = 0; s_adr_o, s_dat_o, s_sel_o, s_cti_o = 0; m_ack_o, m_err_o = 0.
REQ-021 IDLE with any m_cyc_i bit set: the winner SHALL be registered into grant_o and the FSM SHALL enter GRANT on the same edge.
  - Latency: request in cycle k, s_cyc_o high in cycle k+1.
REQ-022 The winner SHALL be the first requester in round-robin order last+1, last+2, last+3, last (mod 4), where last is the previous owner.
REQ-023 GRANT: the owner's cyc, stb, we, adr, dat, sel and cti SHALL drive the slave outputs combinationally.
REQ-024 GRANT: s_ack_i SHALL route to m_ack_o[grant_o] only; all other ack and err bits SHALL be 0.
REQ-025 m_dat_o SHALL equal s_dat_i at all times.
REQ-026 Ownership SHALL be held while the owner's m_cyc_i is high, including across bursts (cti 001/010) and idle stb gaps; there is no preemption.
REQ-027 Owner m_cyc_i low in GRANT: s_cyc_o SHALL be 0 that cycle, and the FSM SHALL go to IDLE next cycle.
  - Re-arbitration therefore costs one IDLE cycle.
REQ-028 A 16-bit stall counter SHALL be cleared on entry to GRANT and whenever s_ack_i=1.
  - It increments each GRANT cycle with s_stb_o=1 and s_ack_i=0.
  - It holds when s_stb_o=0.
REQ-029 Abort: in GRANT with counter==TIMEOUT, s_stb_o=1 and s_ack_i=0, the block SHALL:
  - assert m_err_o[grant_o]=1 and timeout_o=1 for that cycle;
  - force s_cyc_o and s_stb_o to 0 for that cycle;
  - enter IDLE next cycle.
REQ-030 s_ack_i=1 in the same cycle as the abort condition SHALL win: ack delivered, no err, no timeout pulse.
REQ-031 Owner dropping m_cyc_i in the same cycle as s_ack_i SHALL still receive that ack.
REQ-032 An aborted owner that keeps m_cyc_i high SHALL rejoin arbitration as a normal requester, with lowest priority since last = its index.
REQ-033 s_ack_i received in IDLE SHALL be ignored (no m_ack_o).
REQ-034 grant_o SHALL hold its value through IDLE until the next grant.

Reset
REQ-035 sys_rst=1 SHALL force on the next edge:
  - state IDLE, grant_o=0, last=3, counter=0, timeout_o=0;
  - all slave control outputs and m_ack_o, m_err_o low.
REQ-036 Reset asserted mid-transfer SHALL drop s_cyc_o within one cycle, issue no ack or err to the interrupted master, and restore master 0 as highest priority.

Verification
REQ-037 Post-reset, m_cyc_i=4'b1111 -> grants in order 0,1,2,3,0 as each owner drops cyc; one IDLE cycle between grants.
REQ-038 Master 2 single read, slave acks 2 cycles after s_stb_o -> m_ack_o=4'b0100 exactly one cycle; m_dat_o=s_dat_i=32'hDEADBEEF.
REQ-039 Master 1 8-beat burst (cti 010 then 111) while master 3 requests -> master 3 granted only after master 1 drops cyc; all 8 acks reach master 1 only.
REQ-040 TIMEOUT=8, slave never acks, master 0 strobes from cycle 1:
  - m_err_o=4'b0001 and timeout_o=1 in cycle 9;
  - s_cyc_o=0 in cycle 9;
  - IDLE in cycle 10.
REQ-041 TIMEOUT=8, s_ack_i=1 exactly in the abort cycle -> ack delivered; m_err_o=0 and timeout_o=0.
REQ-042 sys_rst pulsed while master 3 owns the bus -> s_cyc_o=0 next cycle; with m_cyc_i=4'b1001 after reset, master 0 is granted.
